// File: rtl/i2c_mon_pkg.sv
// Shared types and constants for the passive I2C bus monitor.
package i2c_mon_pkg;

    // Monitor FSM states.
    typedef enum logic [2:0] {
        MON_IDLE     = 3'd0,
        MON_ADDR     = 3'd1,
        MON_ADDR_ACK = 3'd2,
        MON_DATA     = 3'd3,
        MON_DATA_ACK = 3'd4
    } mon_state_t;

    // SDA level seen in the 9th bit slot.
    localparam logic ACK_LVL  = 1'b0;
    localparam logic NACK_LVL = 1'b1;

    // Codebase rw-bit encoding (inverted w.r.t. the usual I2C convention).
    localparam logic RW_WRITE = 1'b1;
    localparam logic RW_READ  = 1'b0;

    // True when the sampled 9th-bit SDA level is an acknowledge.
    function automatic logic is_ack(input logic sda_lvl);
        return sda_lvl == ACK_LVL;
    endfunction

endpackage

// File: rtl/i2c_line_sync.sv
// Synchroniser and edge/condition detector for the observed SCL/SDA lines.
module i2c_line_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic scl,
    input  logic sda,
    output logic scl_s,
    output logic sda_s,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det
);

    logic [SYNC_STAGES-1:0] scl_sync_q;
    logic [SYNC_STAGES-1:0] sda_sync_q;
    logic                   scl_hist_q;
    logic                   sda_hist_q;

    // Synchroniser chains plus one history flop; reset to an idle (high) bus.
    always_ff @(posedge clk) begin
        if (rst) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_hist_q <= 1'b1;
            sda_hist_q <= 1'b1;
        end else begin
            scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl};
            sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda};
            scl_hist_q <= scl_sync_q[SYNC_STAGES-1];
            sda_hist_q <= sda_sync_q[SYNC_STAGES-1];
        end
    end

    // Edge and START/STOP decode on the synchronised lines.
    always_comb begin
        scl_s     = scl_sync_q[SYNC_STAGES-1];
        sda_s     = sda_sync_q[SYNC_STAGES-1];
        scl_rise  = scl_s & ~scl_hist_q;
        scl_fall  = ~scl_s & scl_hist_q;
        start_det = scl_s & sda_hist_q & ~sda_s;
        stop_det  = scl_s & ~sda_hist_q & sda_s;
    end

endmodule

// File: rtl/i2c_bus_monitor.sv
// Passive I2C bus monitor: decodes bytes/ACKs, summarises transactions and
// counts protocol errors. Observes scl/sda only and drives nothing onto the bus.
module i2c_bus_monitor
    import i2c_mon_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned BYTE_CNT_W  = 8,
    parameter int unsigned ERR_CNT_W   = 8,
    parameter int unsigned TIMEOUT_CYC = 1024,
    parameter logic [6:0]  MATCH_ADDR  = 7'h50
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  scl,
    input  logic                  sda,
    output logic                  evt_valid,
    output logic                  evt_is_addr,
    output logic [7:0]            evt_byte,
    output logic                  evt_ack,
    output logic                  txn_done,
    output logic [6:0]            txn_addr,
    output logic                  txn_rw,
    output logic [BYTE_CNT_W-1:0] txn_bytes,
    output logic                  txn_nack,
    output logic                  addr_match,
    output logic                  busy,
    output logic [ERR_CNT_W-1:0]  err_abort_cnt,
    output logic [ERR_CNT_W-1:0]  err_timeout_cnt
);

    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC + 1);

    logic scl_s, sda_s, scl_rise, scl_fall, start_det, stop_det;

    i2c_line_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_line_sync (
        .clk       (clk),
        .rst       (rst),
        .scl       (scl),
        .sda       (sda),
        .scl_s     (scl_s),
        .sda_s     (sda_s),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .start_det (start_det),
        .stop_det  (stop_det)
    );

    mon_state_t            state_q, state_d;
    logic [2:0]            bit_cnt_q, bit_cnt_d;
    logic [7:0]            shift_q, shift_d;
    logic                  pend_q, pend_d;
    logic                  pend_bit_q, pend_bit_d;
    logic [TMO_W-1:0]      tmo_q, tmo_d;
    logic                  busy_q, busy_d;
    logic [6:0]            addr_q, addr_d;
    logic                  rw_q, rw_d;
    logic [BYTE_CNT_W-1:0] byte_cnt_q, byte_cnt_d;
    logic                  nack_q, nack_d;
    logic                  match_q, match_d;
    logic                  evt_valid_q, evt_valid_d;
    logic                  evt_is_addr_q, evt_is_addr_d;
    logic [7:0]            evt_byte_q, evt_byte_d;
    logic                  evt_ack_q, evt_ack_d;
    logic                  txn_done_q, txn_done_d;
    logic [6:0]            txn_addr_q, txn_addr_d;
    logic                  txn_rw_q, txn_rw_d;
    logic [BYTE_CNT_W-1:0] txn_bytes_q, txn_bytes_d;
    logic                  txn_nack_q, txn_nack_d;
    logic [ERR_CNT_W-1:0]  err_abort_q, err_abort_d;
    logic [ERR_CNT_W-1:0]  err_tmo_q, err_tmo_d;
    logic [7:0]            new_byte;
    logic                  tmo_hit;

    // This cycle is the TIMEOUT_CYC-th consecutive SCL-low cycle of a transaction.
    assign tmo_hit = busy_q && !scl_s && (tmo_q == TMO_W'(TIMEOUT_CYC - 1));

    // Next-state decode. A data bit is sampled on SCL rise but only committed on
    // the following SCL fall, so the SCL rise that precedes a repeated START or a
    // STOP is not mistaken for the first bit of a byte.
    always_comb begin
        state_d       = state_q;
        bit_cnt_d     = bit_cnt_q;
        shift_d       = shift_q;
        pend_d        = pend_q;
        pend_bit_d    = pend_bit_q;
        tmo_d         = tmo_q;
        busy_d        = busy_q;
        addr_d        = addr_q;
        rw_d          = rw_q;
        byte_cnt_d    = byte_cnt_q;
        nack_d        = nack_q;
        match_d       = match_q;
        evt_valid_d   = 1'b0;
        evt_is_addr_d = evt_is_addr_q;
        evt_byte_d    = evt_byte_q;
        evt_ack_d     = evt_ack_q;
        txn_done_d    = 1'b0;
        txn_addr_d    = txn_addr_q;
        txn_rw_d      = txn_rw_q;
        txn_bytes_d   = txn_bytes_q;
        txn_nack_d    = txn_nack_q;
        err_abort_d   = err_abort_q;
        err_tmo_d     = err_tmo_q;
        new_byte      = {shift_q[6:0], pend_bit_q};

        if (state_q == MON_IDLE) begin
            if (start_det) begin
                state_d    = MON_ADDR;
                busy_d     = 1'b1;
                bit_cnt_d  = 3'd0;
                byte_cnt_d = '0;
                nack_d     = 1'b0;
                pend_d     = 1'b0;
                tmo_d      = '0;
            end
        end else if (start_det || stop_det) begin
            txn_done_d  = 1'b1;
            txn_addr_d  = addr_q;
            txn_rw_d    = rw_q;
            txn_bytes_d = byte_cnt_q;
            txn_nack_d  = nack_q;
            if (bit_cnt_q != 3'd0 && !(&err_abort_q)) begin
                err_abort_d = err_abort_q + 1'b1;
            end
            bit_cnt_d  = 3'd0;
            byte_cnt_d = '0;
            nack_d     = 1'b0;
            pend_d     = 1'b0;
            tmo_d      = '0;
            if (start_det) begin
                state_d = MON_ADDR;
            end else begin
                state_d = MON_IDLE;
                busy_d  = 1'b0;
                match_d = 1'b0;
            end
        end else if (tmo_hit) begin
            // Stuck bus: abandon the transaction silently (no summary pulse).
            if (!(&err_tmo_q)) begin
                err_tmo_d = err_tmo_q + 1'b1;
            end
            state_d   = MON_IDLE;
            busy_d    = 1'b0;
            match_d   = 1'b0;
            bit_cnt_d = 3'd0;
            pend_d    = 1'b0;
            tmo_d     = '0;
        end else begin
            tmo_d = scl_s ? '0 : tmo_q + 1'b1;
            case (state_q)
                MON_ADDR, MON_DATA: begin
                    if (scl_rise) begin
                        pend_d     = 1'b1;
                        pend_bit_d = sda_s;
                    end else if (scl_fall && pend_q) begin
                        pend_d  = 1'b0;
                        shift_d = new_byte;
                        if (bit_cnt_q == 3'd7) begin
                            bit_cnt_d = 3'd0;
                            if (state_q == MON_ADDR) begin
                                state_d = MON_ADDR_ACK;
                                addr_d  = new_byte[7:1];
                                rw_d    = new_byte[0];
                                match_d = (new_byte[7:1] == MATCH_ADDR);
                            end else begin
                                state_d = MON_DATA_ACK;
                            end
                        end else begin
                            bit_cnt_d = bit_cnt_q + 3'd1;
                        end
                    end
                end
                MON_ADDR_ACK, MON_DATA_ACK: begin
                    if (scl_rise) begin
                        evt_valid_d   = 1'b1;
                        evt_is_addr_d = (state_q == MON_ADDR_ACK);
                        evt_byte_d    = shift_q;
                        evt_ack_d     = is_ack(sda_s);
                        if (!is_ack(sda_s)) begin
                            nack_d = 1'b1;
                        end
                        if (state_q == MON_DATA_ACK && !(&byte_cnt_q)) begin
                            byte_cnt_d = byte_cnt_q + 1'b1;
                        end
                        state_d = MON_DATA;
                    end
                end
                default: ;
            endcase
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= MON_IDLE;
            bit_cnt_q     <= 3'd0;
            shift_q       <= 8'd0;
            pend_q        <= 1'b0;
            pend_bit_q    <= 1'b0;
            tmo_q         <= '0;
            busy_q        <= 1'b0;
            addr_q        <= 7'd0;
            rw_q          <= 1'b0;
            byte_cnt_q    <= '0;
            nack_q        <= 1'b0;
            match_q       <= 1'b0;
            evt_valid_q   <= 1'b0;
            evt_is_addr_q <= 1'b0;
            evt_byte_q    <= 8'd0;
            evt_ack_q     <= 1'b0;
            txn_done_q    <= 1'b0;
            txn_addr_q    <= 7'd0;
            txn_rw_q      <= 1'b0;
            txn_bytes_q   <= '0;
            txn_nack_q    <= 1'b0;
            err_abort_q   <= '0;
            err_tmo_q     <= '0;
        end else begin
            state_q       <= state_d;
            bit_cnt_q     <= bit_cnt_d;
            shift_q       <= shift_d;
            pend_q        <= pend_d;
            pend_bit_q    <= pend_bit_d;
            tmo_q         <= tmo_d;
            busy_q        <= busy_d;
            addr_q        <= addr_d;
            rw_q          <= rw_d;
            byte_cnt_q    <= byte_cnt_d;
            nack_q        <= nack_d;
            match_q       <= match_d;
            evt_valid_q   <= evt_valid_d;
            evt_is_addr_q <= evt_is_addr_d;
            evt_byte_q    <= evt_byte_d;
            evt_ack_q     <= evt_ack_d;
            txn_done_q    <= txn_done_d;
            txn_addr_q    <= txn_addr_d;
            txn_rw_q      <= txn_rw_d;
            txn_bytes_q   <= txn_bytes_d;
            txn_nack_q    <= txn_nack_d;
            err_abort_q   <= err_abort_d;
            err_tmo_q     <= err_tmo_d;
        end
    end

    // Registered outputs.
    always_comb begin
        evt_valid       = evt_valid_q;
        evt_is_addr     = evt_is_addr_q;
        evt_byte        = evt_byte_q;
        evt_ack         = evt_ack_q;
        txn_done        = txn_done_q;
        txn_addr        = txn_addr_q;
        txn_rw          = txn_rw_q;
        txn_bytes       = txn_bytes_q;
        txn_nack        = txn_nack_q;
        addr_match      = match_q;
        busy            = busy_q;
        err_abort_cnt   = err_abort_q;
        err_timeout_cnt = err_tmo_q;
    end

endmodule

// File: tb/tb_i2c_bus_monitor.sv
// Directed bench: two monitors on one bus (default widths, and 2-bit counters).
module tb_i2c_bus_monitor;

    localparam int QTR = 4;   // clk cycles per quarter SCL period
    localparam int TMO = 64;

    logic clk, rst, scl, sda;

    logic       a_evt_valid, a_evt_is_addr, a_evt_ack, a_txn_done, a_txn_rw, a_txn_nack;
    logic       a_addr_match, a_busy;
    logic [7:0] a_evt_byte, a_txn_bytes, a_err_abort, a_err_tmo;
    logic [6:0] a_txn_addr;

    logic       b_evt_valid, b_evt_is_addr, b_evt_ack, b_txn_done, b_txn_rw, b_txn_nack;
    logic       b_addr_match, b_busy;
    logic [7:0] b_evt_byte;
    logic [1:0] b_txn_bytes, b_err_abort, b_err_tmo;
    logic [6:0] b_txn_addr;

    int checks = 0;
    int errors = 0;
    int a_evt_n = 0;
    int a_txn_n = 0;
    int b_txn_n = 0;
    int e0, t0;

    i2c_bus_monitor #(
        .TIMEOUT_CYC (TMO)
    ) dut_a (
        .clk             (clk),
        .rst             (rst),
        .scl             (scl),
        .sda             (sda),
        .evt_valid       (a_evt_valid),
        .evt_is_addr     (a_evt_is_addr),
        .evt_byte        (a_evt_byte),
        .evt_ack         (a_evt_ack),
        .txn_done        (a_txn_done),
        .txn_addr        (a_txn_addr),
        .txn_rw          (a_txn_rw),
        .txn_bytes       (a_txn_bytes),
        .txn_nack        (a_txn_nack),
        .addr_match      (a_addr_match),
        .busy            (a_busy),
        .err_abort_cnt   (a_err_abort),
        .err_timeout_cnt (a_err_tmo)
    );

    i2c_bus_monitor #(
        .BYTE_CNT_W  (2),
        .ERR_CNT_W   (2),
        .TIMEOUT_CYC (TMO)
    ) dut_b (
        .clk             (clk),
        .rst             (rst),
        .scl             (scl),
        .sda             (sda),
        .evt_valid       (b_evt_valid),
        .evt_is_addr     (b_evt_is_addr),
        .evt_byte        (b_evt_byte),
        .evt_ack         (b_evt_ack),
        .txn_done        (b_txn_done),
        .txn_addr        (b_txn_addr),
        .txn_rw          (b_txn_rw),
        .txn_bytes       (b_txn_bytes),
        .txn_nack        (b_txn_nack),
        .addr_match      (b_addr_match),
        .busy            (b_busy),
        .err_abort_cnt   (b_err_abort),
        .err_timeout_cnt (b_err_tmo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse counters for the one-cycle strobes.
    always @(posedge clk) begin
        if (a_evt_valid) a_evt_n <= a_evt_n + 1;
        if (a_txn_done)  a_txn_n <= a_txn_n + 1;
        if (b_txn_done)  b_txn_n <= b_txn_n + 1;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic waitq();
        repeat (QTR) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        sda = b;
        waitq();
        scl = 1'b1;
        waitq();
        waitq();
        scl = 1'b0;
        waitq();
    endtask

    task automatic send_byte(input logic [7:0] data, input logic ack);
        for (int i = 7; i >= 0; i--) send_bit(data[i]);
        send_bit(!ack);
    endtask

    task automatic i2c_start();
        sda = 1'b1;
        waitq();
        scl = 1'b1;
        waitq();
        sda = 1'b0;
        waitq();
        scl = 1'b0;
        waitq();
    endtask

    task automatic i2c_stop();
        sda = 1'b0;
        waitq();
        scl = 1'b1;
        waitq();
        sda = 1'b1;
        waitq();
        waitq();
    endtask

    initial begin
        rst = 1'b1;
        scl = 1'b1;
        sda = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outs_a", {a_evt_valid, a_evt_is_addr, a_evt_byte, a_evt_ack, a_txn_done,
              a_txn_addr, a_txn_rw, a_txn_bytes, a_txn_nack, a_addr_match, a_busy,
              a_err_abort, a_err_tmo}, 64'd0);
        rst = 1'b0;
        waitq();

        // 1: write to 0x50, one data byte, both ACKed.
        e0 = a_evt_n;
        t0 = a_txn_n;
        i2c_start();
        check("t1_busy", a_busy, 1);
        send_byte(8'hA1, 1'b1);
        check("t1_addr_evt", {a_evt_is_addr, a_evt_byte, a_evt_ack}, {1'b1, 8'hA1, 1'b1});
        check("t1_match", a_addr_match, 1);
        send_byte(8'hA5, 1'b1);
        check("t1_data_evt", {a_evt_is_addr, a_evt_byte, a_evt_ack}, {1'b0, 8'hA5, 1'b1});
        check("t1_match_hold", a_addr_match, 1);
        i2c_stop();
        check("t1_evt_pulses", a_evt_n - e0, 2);
        check("t1_txn_pulses", a_txn_n - t0, 1);
        check("t1_summary", {a_txn_addr, a_txn_rw, a_txn_bytes, a_txn_nack},
              {7'h50, 1'b1, 8'd1, 1'b0});
        check("t1_idle", {a_busy, a_addr_match}, 0);

        // 2: read from 0x23, three data bytes, last one NACKed.
        i2c_start();
        send_byte(8'h46, 1'b1);
        check("t2_match", a_addr_match, 0);
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        send_byte(8'h33, 1'b0);
        check("t2_last_evt", {a_evt_byte, a_evt_ack}, {8'h33, 1'b0});
        i2c_stop();
        check("t2_summary_a", {a_txn_addr, a_txn_rw, a_txn_bytes, a_txn_nack},
              {7'h23, 1'b0, 8'd3, 1'b1});
        check("t2_bytes_b", b_txn_bytes, 3);

        // 3: repeated START after the address ACK, then address 0x51.
        t0 = a_txn_n;
        i2c_start();
        send_byte(8'hA1, 1'b1);
        i2c_start();
        check("t3_rs_pulse", a_txn_n - t0, 1);
        check("t3_rs_summary", {a_txn_addr, a_txn_bytes, a_busy}, {7'h50, 8'd0, 1'b1});
        send_byte(8'hA3, 1'b1);
        check("t3_match_51", a_addr_match, 0);
        i2c_stop();
        check("t3_pulses", a_txn_n - t0, 2);
        check("t3_summary", {a_txn_addr, a_txn_rw, a_txn_bytes}, {7'h51, 1'b1, 8'd0});
        check("t3_no_abort", a_err_abort, 0);

        // 4: STOP after four data bits.
        t0 = a_txn_n;
        i2c_start();
        send_byte(8'hA1, 1'b1);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        i2c_stop();
        check("t4_pulse", a_txn_n - t0, 1);
        check("t4_abort", {a_err_abort, 6'd0, b_err_abort}, {8'd1, 6'd0, 2'd1});
        check("t4_idle", a_busy, 0);

        // 5: SCL stuck low mid-byte, then a normal transaction.
        t0 = a_txn_n;
        i2c_start();
        send_byte(8'hA1, 1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        repeat (TMO + 20) @(posedge clk);
        #1;
        check("t5_timeout", {a_err_tmo, 6'd0, b_err_tmo}, {8'd1, 6'd0, 2'd1});
        check("t5_busy", a_busy, 0);
        check("t5_no_txn", a_txn_n - t0, 0);
        sda = 1'b1;
        waitq();
        scl = 1'b1;
        waitq();
        i2c_start();
        send_byte(8'hA1, 1'b1);
        send_byte(8'h3C, 1'b1);
        i2c_stop();
        check("t5_recover_pulse", a_txn_n - t0, 1);
        check("t5_recover", {a_txn_addr, a_txn_bytes, a_evt_byte}, {7'h50, 8'd1, 8'h3C});

        // 6a: five more aborts saturate the 2-bit counter.
        for (int k = 0; k < 5; k++) begin
            i2c_start();
            send_byte(8'hA1, 1'b1);
            send_bit(1'b1);
            i2c_stop();
        end
        check("t6_abort_a", a_err_abort, 6);
        check("t6_abort_b_sat", b_err_abort, 3);

        // 6b: five data bytes saturate the 2-bit byte counter.
        i2c_start();
        send_byte(8'hA1, 1'b1);
        for (int k = 0; k < 5; k++) send_byte(8'h5A, 1'b1);
        i2c_stop();
        check("t6_bytes_a", a_txn_bytes, 5);
        check("t6_bytes_b_sat", b_txn_bytes, 3);

        // 6c: synchronous reset in the middle of a byte.
        e0 = a_evt_n;
        t0 = a_txn_n;
        i2c_start();
        send_byte(8'hA1, 1'b1);
        send_bit(1'b1);
        send_bit(1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("t6_rst_outs_a", {a_evt_valid, a_evt_is_addr, a_evt_byte, a_evt_ack, a_txn_done,
              a_txn_addr, a_txn_rw, a_txn_bytes, a_txn_nack, a_addr_match, a_busy,
              a_err_abort, a_err_tmo}, 64'd0);
        check("t6_rst_outs_b", {b_txn_bytes, b_err_abort, b_err_tmo, b_busy, b_evt_byte}, 0);
        rst = 1'b0;
        e0 = a_evt_n;
        t0 = a_txn_n;
        for (int k = 0; k < 6; k++) send_bit(1'b1);
        send_bit(1'b0);
        i2c_stop();
        check("t6_post_rst_ignored", {a_busy, 7'd0, 8'(a_evt_n - e0), 8'(a_txn_n - t0)}, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/i2c_bus_monitor.md
Name: i2c_bus_monitor

Overview:
- Synthesizable, passive I2C bus monitor; the hardware successor to the simulation-only protocol checks on the master/slave pair.
- Oversamples scl/sda on the system clock and detects START, repeated START and STOP.
- Decodes address/rw, data bytes and ACK/NACK, and reports per-byte events and a per-transaction summary.
- Flags protocol errors (mid-byte abort, SCL-low timeout) with saturating counters. Sits beside the bus in the top level and drives nothing onto it.

Parameters:
- SYNC_STAGES, 2: synchroniser depth on scl/sda (legal range 2..4).
- BYTE_CNT_W, 8: width of the per-transaction data-byte counter; saturates.
- ERR_CNT_W, 8: width of each error counter; saturates.
- TIMEOUT_CYC, 1024: clk cycles with scl held low inside a transaction before a timeout is declared.
- MATCH_ADDR, 7'h50: address compared for addr_match.

Ports:
- clk  in  1  system clock; must be at least 4x the SCL frequency.
- rst  in  1  synchronous, active-high reset.
- scl  in  1  raw bus clock line (observed only).
- sda  in  1  raw bus data line (observed only).
- evt_valid  out  1  one-cycle pulse: a byte plus its ack bit has completed.
- evt_is_addr  out  1  1 = address byte, 0 = data byte.
- evt_byte  out  8  completed byte, MSB first on the bus.
- evt_ack  out  1  1 = ACK (sda low at the 9th scl rise).
- txn_done  out  1  one-cycle pulse on STOP or repeated START that closes a transaction.
- txn_addr  out  7  address of the closed transaction.
- txn_rw  out  1  rw bit of the closed transaction (1 = write, the codebase encoding).
- txn_bytes  out  BYTE_CNT_W  data bytes in the closed transaction.
- txn_nack  out  1  a NACK occurred in the closed transaction.
- addr_match  out  1  level: the current address equals MATCH_ADDR; cleared on STOP.
- busy  out  1  level: high from START to STOP.
- err_abort_cnt  out  ERR_CNT_W  count of START/STOP detected while bit_cnt != 0.
- err_timeout_cnt  out  ERR_CNT_W  count of SCL-low timeouts.

Behaviour:
- Reset values: all outputs 0; synchroniser flops reset to 1 (idle bus); FSM to MON_IDLE; bit_cnt, shift register and timeout counter to 0.
- Input path: scl/sda pass through SYNC_STAGES flops, plus one history flop for edge detection.
  - scl_rise = synced scl 0→1; sda_fall/sda_rise defined the same way on synced sda.
  - START = sda_fall while synced scl = 1. STOP = sda_rise while synced scl = 1.
  - Latency from a raw pin change to detection is SYNC_STAGES+1 cycles.
- FSM states: MON_IDLE, MON_ADDR, MON_ADDR_ACK, MON_DATA, MON_DATA_ACK.
  - MON_IDLE: START → MON_ADDR, busy = 1, bit_cnt = 0, byte counter = 0, nack flag = 0.
  - MON_ADDR / MON_DATA: on each scl_rise, shift sda in (MSB first) and increment bit_cnt. At bit_cnt == 7 the shift completes, go to the matching *_ACK state and set bit_cnt = 0.
  - On leaving MON_ADDR: latch addr = byte[7:1] and rw = byte[0]; addr_match updates on the same cycle.
  - *_ACK: on scl_rise, sample ack = !sda and pulse evt_valid with the byte. Then go to MON_DATA.
    - MON_DATA_ACK only: increment the byte counter (saturating at all-ones).
    - NACK sets the nack flag.
    - A NACK in MON_ADDR_ACK still proceeds to MON_DATA; the transaction closes only on STOP or START.
- START in any non-idle state (repeated START):
  - Pulse txn_done with the current summary, then restart at MON_ADDR.
  - If bit_cnt != 0, also increment err_abort_cnt.
- STOP in any non-idle state:
  - Pulse txn_done, go to MON_IDLE, drop busy and addr_match.
  - If bit_cnt != 0, also increment err_abort_cnt.
- START/STOP have priority over scl_rise in the same cycle; they cannot coincide because scl must be high.
- Timeout: the counter runs while busy and synced scl = 0, and clears on scl high.
  - On reaching TIMEOUT_CYC: increment err_timeout_cnt, go to MON_IDLE, busy = 0. No txn_done pulse.
- txn_* outputs hold their values until the next txn_done. evt_* fields hold until the next evt_valid.
- Error counters saturate at all-ones and clear only on rst.
- rst asserted mid-transaction returns the block to the reset values the next cycle. The monitor then waits for a fresh START; any bus activity before that is ignored.

Decomposition:
- Package i2c_mon_pkg: mon_state_t enum, the ACK/NACK constants, and the rw encoding constants (RW_WRITE = 1, RW_READ = 0).
- One sub-module, i2c_line_sync:
  - Parameterised synchroniser plus edge detector for scl/sda.
  - Outputs scl_s, sda_s, scl_rise, start_det, stop_det.
  - Instantiated once.

Test Plan:
1. Write, addr 0x50, rw = 1, data 0xA5, both ACKed, then STOP → two evt_valid pulses (0xA1 is_addr = 1 ack = 1; 0xA5 is_addr = 0 ack = 1); txn_done with addr = 0x50, rw = 1, bytes = 1, nack = 0; addr_match = 1 until STOP.
2. Read, addr 0x23, rw = 0, 3 data bytes, last byte NACKed → txn_bytes = 3, txn_nack = 1, addr_match = 0.
3. Repeated START after the address ACK, new address 0x51, then STOP → two txn_done pulses (bytes = 0 each); err_abort_cnt unchanged.
4. STOP injected after 4 data bits → txn_done pulses, err_abort_cnt = 1, FSM back in MON_IDLE.
5. scl held low for TIMEOUT_CYC cycles mid-byte → err_timeout_cnt = 1, busy = 0, no txn_done; the next START is decoded normally.
6. Saturation: ERR_CNT_W = 2 with five aborts → err_abort_cnt = 3. BYTE_CNT_W = 2 with five data bytes → txn_bytes = 3. Synchronous rst mid-byte → all outputs 0 next cycle.
